output_argmax: RTL and testbench
================================

# output_argmax

Classification stage downstream of the network control unit. When the control unit raises `compare` after the last layer-1 accumulation, this block reads the ten output-neuron accumulators one at a time from the output register bank. It selects the index of the largest signed value and presents it as the recognised digit with a sticky `done` flag. It is the final stage before the display/UART logic.

## Interface
- `N_CLASSES`, 10, number of output neurons scanned (indices 0..N_CLASSES-1)
- `DATA_W`, 16, width of each accumulator value, signed two's complement
- `IDX_W`, 4, width of index/address; must satisfy 2^IDX_W >= N_CLASSES

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `compare`  in  1  level from control unit; a rising edge starts a scan
- `rd_en`  out  1  one-cycle read request to output bank
- `rd_addr`  out  IDX_W  neuron index being requested
- `rd_data`  in  DATA_W  signed accumulator value; valid only with `rd_valid`
- `rd_valid`  in  1  read response strobe, latency >= 1 cycle after `rd_en`
- `busy`  out  1  high while a scan is in progress
- `done`  out  1  high from scan completion until next start or reset
- `digit`  out  IDX_W  winning index; valid while `done`=1
- `max_value`  out  DATA_W  winning accumulator value; valid while `done`=1

## Operation
- Start detection: register `compare` into `compare_d`. Start = `compare & ~compare_d`. A held-high `compare` starts exactly one scan. A falling `compare` mid-scan is ignored.
- States:
  - IDLE: waits for start, then goes to REQ with idx=0.
  - REQ: `rd_en`=1 and `rd_addr`=idx for exactly one cycle, then goes to WAIT.
  - WAIT: holds until `rd_valid`=1. Compare/update, then:
    - if idx==N_CLASSES-1, go to DONE;
    - otherwise idx+1 and go to REQ.
  - DONE: `done`=1. A start clears `done` and goes to REQ with idx=0.
- Update rule, evaluated in WAIT on `rd_valid`:
  - if idx==0 or signed(`rd_data`) > signed(best), load best=`rd_data` and best_idx=idx;
  - ties keep the lower index.
  - Comparison is a full DATA_W signed compare with no saturation.
- `rd_valid` in any state other than WAIT is ignored and does not alter best/idx.
- A start while busy (only possible after `compare` drops and re-rises) is ignored.
- `digit`/`max_value` are driven from best_idx/best registers.
  - They hold their last value when not `done`.
  - They are not blanked at the start of a new scan; consumers qualify them with `done`.
- `busy` = state is REQ or WAIT.

## Timing
- Reset values:
  - state=IDLE, idx=0, `compare_d`=0, best=0, best_idx=0;
  - `rd_en`=0, `rd_addr`=0, `busy`=0, `done`=0, `digit`=0, `max_value`=0.
- Reset asserted mid-scan aborts at once; no further `rd_en`. After release, a new rising edge of `compare` is required. If `compare` is still high at release, `compare_d` is 0, so the high level counts as an edge on the first clock.
- Edge E0 samples start, then REQ. With read latency L, each class costs L+1 cycles.
- With L=1: `rd_en` pulses after edges E0, E2, …, E18. `done` rises after edge E20 and `busy` falls on the same edge.
- `done` and `busy` are never high together.
- `rd_en` is never high for two consecutive cycles, and only one request is outstanding at a time.

## Structure
- Shared package holds:
  - `N_CLASSES`, `DATA_W`, `IDX_W` defaults;
  - state encoding constants IDLE/REQ/WAIT/DONE (2-bit).
  - The same package supplies the output bank depth.
- Single module; no sub-module required. The edge detector and the compare/update are inline.
- Expected size: about 150 lines.

## Test plan
- Values [3,-5,100,7,0,99,-1,2,50,10], L=1, `compare` held high → `done` after 20 edges, `digit`=2, `max_value`=100, exactly 10 `rd_en` pulses at addresses 0..9.
- All negative [-9,-3,-8,-3,-100,-7,-4,-5,-6,-32768] → `digit`=1, `max_value`=-3 (tie keeps lower index; negative max handled).
- L=3, random `rd_valid` delays 1..5, plus spurious `rd_valid` in REQ/IDLE → result unchanged vs golden argmax, `rd_en` never re-issued before response.
- `reset` asserted while idx=5 in WAIT → all outputs at reset values that cycle; `compare` kept high through release → new scan starts on first clock, full 10 reads.
- After `done`: drop `compare` 2 cycles, load new values with max at index 9 (32767), re-raise → `done` drops on start edge and returns with `digit`=9, `max_value`=32767.
- `compare` held high after `done` for 50 cycles → no new `rd_en`, `done` stays 1.

Source files
------------

// File: rtl/output_argmax_pkg.sv
// Shared parameters and state encoding for the output-layer argmax stage.
package output_argmax_pkg;

    localparam int N_CLASSES  = 10;
    localparam int DATA_W     = 16;
    localparam int IDX_W      = 4;
    localparam int BANK_DEPTH = N_CLASSES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/output_argmax.sv
// Scans the output-neuron accumulators one read at a time and reports the index
// and value of the largest signed entry, with a sticky done flag.
module output_argmax
    import output_argmax_pkg::*;
#(
    parameter int N_CLASSES = output_argmax_pkg::N_CLASSES,
    parameter int DATA_W    = output_argmax_pkg::DATA_W,
    parameter int IDX_W     = output_argmax_pkg::IDX_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     compare,
    output logic                     rd_en,
    output logic [IDX_W-1:0]         rd_addr,
    input  logic signed [DATA_W-1:0] rd_data,
    input  logic                     rd_valid,
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W-1:0]         digit,
    output logic signed [DATA_W-1:0] max_value
);

    state_t                     state;
    state_t                     state_nxt;
    logic                       compare_d;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           best_idx;
    logic signed [DATA_W-1:0]   best;
    logic                       start;
    logic                       last;
    logic                       take;

    assign start = compare & ~compare_d;
    assign last  = (idx == IDX_W'(N_CLASSES - 1));
    // The first read always seeds best; strict > keeps the lower index on ties.
    assign take  = (idx == '0) || (rd_data > best);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            compare_d <= 1'b0;
            idx       <= '0;
            best      <= '0;
            best_idx  <= '0;
        end else begin
            state     <= state_nxt;
            compare_d <= compare;
            case (state)
                IDLE, DONE: begin
                    if (start) idx <= '0;
                end
                WAIT: begin
                    if (rd_valid) begin
                        if (take) begin
                            best     <= rd_data;
                            best_idx <= idx;
                        end
                        if (!last) idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = REQ;
            end
            REQ: begin
                rd_en     = 1'b1;
                busy      = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (rd_valid) state_nxt = last ? DONE : REQ;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_addr   = idx;
    assign digit     = best_idx;
    assign max_value = best;

endmodule

// File: tb/tb_output_argmax.sv
// Directed bench for output_argmax: a behavioural output bank answers reads with
// configurable latency and optional spurious strobes; each task checks one scenario.
module tb_output_argmax;
    import output_argmax_pkg::*;

    typedef logic signed [DATA_W-1:0] vec_t [BANK_DEPTH];

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     compare;
    logic                     rd_en;
    logic [IDX_W-1:0]         rd_addr;
    logic signed [DATA_W-1:0] rd_data;
    logic                     rd_valid;
    logic                     busy;
    logic                     done;
    logic [IDX_W-1:0]         digit;
    logic signed [DATA_W-1:0] max_value;

    vec_t mem;
    int   checks;
    int   errors;
    int   rd_count;
    int   proto_viol;
    int   mon_viol;
    int   addr_log[$];
    int   lat_fixed;
    bit   rand_lat;
    bit   spur;

    output_argmax dut (
        .clk      (clk),
        .reset    (reset),
        .compare  (compare),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done),
        .digit    (digit),
        .max_value(max_value)
    );

    always #5 clk = ~clk;

    // Output bank: one response per request, latency counted in clock edges.
    initial begin
        int a;
        int lat;
        rd_valid   = 1'b0;
        rd_data    = '0;
        rd_count   = 0;
        proto_viol = 0;
        @(posedge clk); #1;
        forever begin
            if (rd_en && !reset) begin
                a = int'(rd_addr);
                addr_log.push_back(a);
                rd_count++;
                lat = rand_lat ? int'($urandom_range(5, 1)) : lat_fixed;
                if (spur) begin
                    rd_valid = 1'b1;
                    rd_data  = 16'sh7fff;
                end else begin
                    rd_valid = 1'b0;
                end
                repeat (lat) begin
                    @(posedge clk); #1;
                    rd_valid = 1'b0;
                    if (rd_en) proto_viol++;
                end
                rd_valid = 1'b1;
                rd_data  = (a < BANK_DEPTH) ? mem[a] : '0;
                @(posedge clk); #1;
                rd_valid = 1'b0;
            end else begin
                rd_valid = spur ? ~rd_valid : 1'b0;
                if (spur) rd_data = 16'sh7fff;
                @(posedge clk); #1;
            end
        end
    end

    initial begin
        logic prev;
        prev     = 1'b0;
        mon_viol = 0;
        forever begin
            @(posedge clk); #1;
            if (done && busy) mon_viol++;
            if (rd_en && prev) mon_viol++;
            prev = rd_en;
        end
    end

    task automatic wait_done(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            n++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_bad_addrs(input int base, output int bad);
        bad = 0;
        if (addr_log.size() < base + N_CLASSES) bad = N_CLASSES;
        else
            for (int i = 0; i < N_CLASSES; i++)
                if (addr_log[base + i] != i) bad++;
    endtask

    task automatic restart_scan();
        compare = 1'b0;
        repeat (2) begin
            @(posedge clk); #2;
        end
        compare = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk); #2;
        end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
        checks++; if (rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (digit !== '0) begin errors++; $display("FAIL reset_digit: got %0d expected 0", digit); end
        checks++; if (max_value !== '0) begin errors++; $display("FAIL reset_max: got %0d expected 0", max_value); end
        reset = 1'b0;
        spur  = 1'b1;
        repeat (4) begin
            @(posedge clk); #2;
        end
        spur = 1'b0;
        checks++;
        if (busy !== 1'b0 || digit !== '0 || max_value !== '0) begin
            errors++;
            $display("FAIL idle_spurious: got busy=%b digit=%0d max=%0d expected 0/0/0", busy, digit, max_value);
        end
        @(posedge clk); #2;
    endtask

    task automatic test_basic();
        int n; bit ok; int base; int bad;
        mem  = '{16'sd3, -16'sd5, 16'sd100, 16'sd7, 16'sd0, 16'sd99, -16'sd1, 16'sd2, 16'sd50, 16'sd10};
        base = rd_count;
        compare = 1'b1;
        wait_done(n, ok);
        // Start edge E0 plus 20 further edges.
        checks++; if (!ok || n != 21) begin errors++; $display("FAIL basic_latency: got %0d edges expected 21", n); end
        checks++; if (digit !== 4'd2) begin errors++; $display("FAIL basic_digit: got %0d expected 2", digit); end
        checks++; if (max_value !== 16'sd100) begin errors++; $display("FAIL basic_max: got %0d expected 100", max_value); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", busy); end
        checks++; if (rd_count - base != 10) begin errors++; $display("FAIL basic_reads: got %0d expected 10", rd_count - base); end
        count_bad_addrs(base, bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL basic_addrs: got %0d bad expected 0", bad); end
    endtask

    task automatic test_negative();
        int n; bit ok; int base;
        mem  = '{-16'sd9, -16'sd3, -16'sd8, -16'sd3, -16'sd100, -16'sd7, -16'sd4, -16'sd5, -16'sd6, -16'sd32768};
        base = rd_count;
        restart_scan();
        @(posedge clk); #2;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || rd_en !== 1'b1) begin
            errors++;
            $display("FAIL neg_start_edge: got done=%b busy=%b rd_en=%b expected 0/1/1", done, busy, rd_en);
        end
        wait_done(n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL neg_timeout: got no done expected done"); end
        checks++; if (digit !== 4'd1) begin errors++; $display("FAIL neg_digit: got %0d expected 1", digit); end
        checks++; if (max_value !== -16'sd3) begin errors++; $display("FAIL neg_max: got %0d expected -3", max_value); end
        checks++; if (rd_count - base != 10) begin errors++; $display("FAIL neg_reads: got %0d expected 10", rd_count - base); end
    endtask

    task automatic test_latency();
        int n; bit ok; int base; int bad;
        mem      = '{16'sd5, 16'sd20, -16'sd7, 16'sd20, 16'sd3, 16'sd19, 16'sd0, -16'sd1, 16'sd8, 16'sd6};
        base     = rd_count;
        rand_lat = 1'b1;
        spur     = 1'b1;
        restart_scan();
        checks++;
        if (digit !== 4'd1 || max_value !== -16'sd3) begin
            errors++;
            $display("FAIL lat_done_spurious: got digit=%0d max=%0d expected 1/-3", digit, max_value);
        end
        wait_done(n, ok);
        rand_lat = 1'b0;
        spur     = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL lat_timeout: got no done expected done"); end
        checks++; if (digit !== 4'd1) begin errors++; $display("FAIL lat_digit: got %0d expected 1", digit); end
        checks++; if (max_value !== 16'sd20) begin errors++; $display("FAIL lat_max: got %0d expected 20", max_value); end
        count_bad_addrs(base, bad);
        checks++; if (bad != 0 || rd_count - base != 10) begin errors++; $display("FAIL lat_reads: got %0d reads %0d bad expected 10/0", rd_count - base, bad); end
    endtask

    task automatic test_reset_mid_scan();
        int n; bit ok; int base; int bad; bit hit; bit leak;
        mem  = '{16'sd3, -16'sd5, 16'sd100, 16'sd7, 16'sd0, 16'sd99, -16'sd1, 16'sd2, 16'sd50, 16'sd10};
        base = rd_count;
        hit  = 1'b0;
        restart_scan();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (rd_count - base == 6) begin
                hit = 1'b1;
                break;
            end
        end
        @(posedge clk); #2;
        checks++;
        if (!hit || busy !== 1'b1 || rd_addr !== 4'd5) begin
            errors++;
            $display("FAIL rst_pre_wait: got hit=%b busy=%b addr=%0d expected 1/1/5", hit, busy, rd_addr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({rd_en, rd_addr, busy, done, digit, max_value} !== '0) begin
            errors++;
            $display("FAIL rst_async: got rd_en=%b addr=%0d busy=%b done=%b digit=%0d max=%0d expected all 0",
                     rd_en, rd_addr, busy, done, digit, max_value);
        end
        leak = 1'b0;
        repeat (3) begin
            @(posedge clk); #2;
            if (rd_en !== 1'b0 || busy !== 1'b0) leak = 1'b1;
        end
        checks++; if (leak) begin errors++; $display("FAIL rst_hold: got activity during reset expected none"); end
        base  = rd_count;
        reset = 1'b0;
        @(posedge clk); #2;
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== 4'd0) begin
            errors++;
            $display("FAIL rst_restart: got rd_en=%b addr=%0d expected 1/0", rd_en, rd_addr);
        end
        wait_done(n, ok);
        checks++; if (!ok || digit !== 4'd2 || max_value !== 16'sd100) begin errors++; $display("FAIL rst_result: got digit=%0d max=%0d expected 2/100", digit, max_value); end
        count_bad_addrs(base, bad);
        checks++; if (bad != 0 || rd_count - base != 10) begin errors++; $display("FAIL rst_reads: got %0d reads %0d bad expected 10/0", rd_count - base, bad); end
    endtask

    task automatic test_new_max_last();
        int n; bit ok;
        mem = '{16'sd32766, -16'sd32768, 16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd32767};
        restart_scan();
        @(posedge clk); #2;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL last_done_drop: got %b expected 0", done); end
        wait_done(n, ok);
        checks++; if (!ok || digit !== 4'd9) begin errors++; $display("FAIL last_digit: got %0d expected 9", digit); end
        checks++; if (max_value !== 16'sd32767) begin errors++; $display("FAIL last_max: got %0d expected 32767", max_value); end
    endtask

    task automatic test_hold_compare();
        int base; bit dropped;
        base    = rd_count;
        dropped = 1'b0;
        repeat (50) begin
            @(posedge clk); #2;
            if (done !== 1'b1) dropped = 1'b1;
        end
        checks++; if (dropped) begin errors++; $display("FAIL hold_done: got done low expected sticky high"); end
        checks++; if (rd_count - base != 0) begin errors++; $display("FAIL hold_reads: got %0d expected 0", rd_count - base); end
        checks++; if (digit !== 4'd9) begin errors++; $display("FAIL hold_digit: got %0d expected 9", digit); end
    endtask

    task automatic test_protocol();
        checks++; if (proto_viol != 0) begin errors++; $display("FAIL proto_outstanding: got %0d expected 0", proto_viol); end
        checks++; if (mon_viol != 0) begin errors++; $display("FAIL proto_overlap: got %0d expected 0", mon_viol); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        compare   = 1'b0;
        spur      = 1'b0;
        rand_lat  = 1'b0;
        lat_fixed = 1;
        mem       = '{default: '0};
        test_reset();
        test_basic();
        test_negative();
        test_latency();
        test_reset_mid_scan();
        test_new_max_last();
        test_hold_compare();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
